// File: rtl/rr_priority_arbiter.sv
// Registered N-way priority arbiter with a selectable round-robin mode.
// Fixed mode: the highest requesting index wins and keeps the grant for as
// long as it keeps requesting. RR mode: the search starts at a rotating
// pointer, and an owner is forced to re-arbitrate after MAX_HOLD cycles.
module rr_priority_arbiter #(
    parameter int N        = 6,
    parameter int MAX_HOLD = 4,
    localparam int IW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rr_mode,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [IW-1:0] PTR_TOP = IW'(N - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [HW-1:0] hold_cnt;

    logic          timeout;
    logic [N-1:0]  arb_vec;
    logic [IW-1:0] win_idx;
    logic          win_any;
    logic          do_grant;
    logic          do_hold;
    logic          go_idle;
    logic [IW-1:0] grant_idx;

    // Winner of vector v. Fixed mode: highest set index. RR mode: first set
    // bit in the order p, p-1, ..., 0, N-1, ..., p+1. Later loop iterations
    // overwrite earlier ones, so the last one visited has top priority.
    function automatic logic [IW-1:0] pick(input logic [N-1:0]  v,
                                           input logic          rr,
                                           input logic [IW-1:0] p);
        logic [IW-1:0] w;
        int            j;
        w = '0;
        if (!rr) begin
            for (int i = 0; i < N; i++) begin
                if (v[i]) w = IW'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                j = (int'(p) + N - i) % N;
                if (v[j]) w = IW'(j);
            end
        end
        return w;
    endfunction

    // Decide this edge's action: new grant, hold the owner, or go idle.
    // A timed-out owner is masked out of its own arbitration and is only
    // regranted when nobody else is asking.
    always_comb begin
        timeout   = (state == BUSY) && rr_mode && req[gnt_idx] && (hold_cnt == HOLD_MAX);
        arb_vec   = req;
        if (timeout) arb_vec[gnt_idx] = 1'b0;
        win_idx   = pick(arb_vec, rr_mode, ptr);
        win_any   = |arb_vec;
        do_grant  = 1'b0;
        do_hold   = 1'b0;
        go_idle   = 1'b0;
        grant_idx = win_idx;
        if (state == IDLE) begin
            do_grant = win_any;
        end else if (req[gnt_idx] && !timeout) begin
            do_hold = 1'b1;
        end else if (win_any) begin
            do_grant = 1'b1;
        end else if (timeout) begin
            do_grant  = 1'b1;
            grant_idx = gnt_idx;
        end else begin
            go_idle = 1'b1;
        end
    end

    // State, registered grant outputs, rotating pointer and hold counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= PTR_TOP;
            hold_cnt  <= '0;
        end else if (do_grant) begin
            state     <= BUSY;
            gnt       <= N'(1) << grant_idx;
            gnt_idx   <= grant_idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= HW'(1);
            if (rr_mode) begin
                ptr <= (grant_idx == '0) ? PTR_TOP : grant_idx - 1'b1;
            end
        end else if (do_hold) begin
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
        end else if (go_idle) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Scoreboard bench for rr_priority_arbiter (N=6, MAX_HOLD=4). The stimulus
// process applies req/rr_mode at the falling edge and queues the grant
// expected after the next rising edge; the monitor pops and compares.
module tb_rr_priority_arbiter;

    logic       clk;
    logic       reset;
    logic       rr_mode;
    logic [5:0] req;
    logic [5:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int n_vec  = 0;
    int n_miss = 0;

    logic [5:0] exp_q[$];

    rr_priority_arbiter #(.N(6), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rr_mode   (rr_mode),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] idx_of(input logic [5:0] g);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            if (g[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard compare when an entry is due.
    always begin
        logic [5:0] e;
        @(posedge clk);
        #1;
        check("valid_eq_or_gnt", int'(gnt_valid), int'(gnt != 6'b0));
        check("gnt_onehot0", int'($countones(gnt) <= 1), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gnt", int'(gnt), int'(e));
            check("gnt_idx", int'(gnt_idx), int'(idx_of(e)));
            check("gnt_valid", int'(gnt_valid), int'(e != 6'b0));
        end
    end

    task automatic step(input logic [5:0] r, input logic m, input logic [5:0] eg);
        @(negedge clk);
        req     = r;
        rr_mode = m;
        exp_q.push_back(eg);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        req     = '0;
        rr_mode = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] k;
        reset   = 1'b1;
        rr_mode = 1'b0;
        req     = '0;
        #2;
        check("reset_gnt", int'(gnt), 0);
        check("reset_valid", int'(gnt_valid), 0);
        do_reset();

        // Reset asserted mid-cycle while owner 3 holds the grant.
        step(6'b001000, 1'b0, 6'b001000);
        step(6'b001000, 1'b0, 6'b001000);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_gnt", int'(gnt), 0);
        check("async_rst_idx", int'(gnt_idx), 0);
        check("async_rst_valid", int'(gnt_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        req   = '0;

        // Idle stays idle.
        step(6'b000000, 1'b0, 6'b000000);
        step(6'b000000, 1'b1, 6'b000000);

        // Fixed priority: highest wins, no timeout, then handover on release.
        do_reset();
        for (int i = 0; i < 11; i++) step(6'b101001, 1'b0, 6'b100000);
        step(6'b001001, 1'b0, 6'b001000);
        step(6'b000001, 1'b0, 6'b000001);

        // Round-robin contention: 4 cycles each, 5 down to 0, wrap to 5.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            k = 3'(5 - i / 4);
            step(6'b111111, 1'b1, 6'b000001 << k);
        end
        for (int i = 0; i < 4; i++) step(6'b111111, 1'b1, 6'b100000);
        step(6'b111111, 1'b1, 6'b010000);

        // Sole requester is regranted on timeout without a gap.
        do_reset();
        for (int i = 0; i < 13; i++) step(6'b000100, 1'b1, 6'b000100);
        // After the regrant ptr is 1, so another requester wins next timeout.
        step(6'b100100, 1'b1, 6'b000100);
        step(6'b100100, 1'b1, 6'b000100);
        step(6'b100100, 1'b1, 6'b000100);
        step(6'b100100, 1'b1, 6'b100000);

        // Release handover and idle in RR mode.
        do_reset();
        step(6'b001010, 1'b1, 6'b001000);
        step(6'b000010, 1'b1, 6'b000010);
        step(6'b000000, 1'b1, 6'b000000);
        step(6'b000000, 1'b1, 6'b000000);

        // Mode switch: fixed-mode owner 5 kept, times out, 0 takes over.
        do_reset();
        step(6'b100001, 1'b0, 6'b100000);
        for (int i = 0; i < 3; i++) step(6'b100001, 1'b1, 6'b100000);
        step(6'b100001, 1'b1, 6'b000001);
        step(6'b100001, 1'b1, 6'b000001);

        // Non-owner req changes do not disturb a held grant.
        do_reset();
        step(6'b000010, 1'b1, 6'b000010);
        step(6'b110010, 1'b1, 6'b000010);
        step(6'b010010, 1'b1, 6'b000010);
        step(6'b010000, 1'b1, 6'b010000);

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
